// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter with a power-of-two FIFO in front of the shifter.
// Frames: start, DataBits data (LSB first), optional parity, StopBits stops.
module uart_tx_fifo #(
   parameter int ClockFrequencyHz = 66_000_000,
   parameter int BaudRate         = 9600,
   parameter int DataBits         = 8,
   parameter int ParityMode       = 0,
   parameter int StopBits         = 1,
   parameter int FifoDepth        = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DataBits-1:0]          wr_data,
   input  logic                         wr_en,
   output logic                         full,
   output logic [$clog2(FifoDepth):0]   count,
   output logic                         ovf,
   input  logic                         ovf_clr,
   output logic                         tx,
   output logic                         bsy
);

   localparam int BitTime = ClockFrequencyHz / BaudRate;
   localparam int AW      = $clog2(FifoDepth);
   localparam int CW      = (BitTime > 1) ? $clog2(BitTime) : 1;
   localparam int IW      = $clog2(DataBits + 1);

   localparam logic [CW-1:0] BitLast = CW'(BitTime - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic [DataBits-1:0] mem [FifoDepth];
   logic [AW:0]         wr_ptr;
   logic [AW:0]         rd_ptr;
   logic [DataBits-1:0] head;
   logic                push;
   logic                pop;
   logic                nonempty;

   logic [2:0]          state;
   logic [CW-1:0]       cnt;
   logic [IW-1:0]       bit_idx;
   logic                stop_idx;
   logic [DataBits-1:0] shreg;
   logic                par;
   logic                bit_end;
   logic                last_stop;

   assign count     = wr_ptr - rd_ptr;
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign nonempty  = (count != '0);
   assign push      = wr_en && !full;
   assign head      = mem[rd_ptr[AW-1:0]];
   assign bit_end   = (cnt == '0);
   assign last_stop = (stop_idx == 1'(StopBits - 1));
   assign bsy       = (state != IDLE) || nonempty;

   // Pop the head when idle, or at the very end of the last stop bit.
   always_comb begin
      pop = 1'b0;
      if (nonempty) begin
         if (state == IDLE)
            pop = 1'b1;
         else if (state == STOP && bit_end && last_stop)
            pop = 1'b1;
      end
   end

   // FIFO storage; contents need no reset, pointers define validity.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   // Read/write pointers with an extra wrap bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Sticky overflow; a dropped write beats a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf <= 1'b0;
      else if (wr_en && full)
         ovf <= 1'b1;
      else if (ovf_clr)
         ovf <= 1'b0;
   end

   // Frame shifter; a pop always starts a fresh frame with the start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tx       <= 1'b1;
         cnt      <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par      <= 1'b0;
      end else if (pop) begin
         shreg    <= head;
         par      <= (^head) ^ (ParityMode == 2);
         tx       <= 1'b0;
         cnt      <= BitLast;
         state    <= START;
      end else if (state != IDLE) begin
         if (!bit_end) begin
            cnt <= cnt - CW'(1);
         end else begin
            cnt <= BitLast;
            unique case (state)
               START: begin
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_idx <= IW'(1);
                  state   <= DATA;
               end
               DATA: begin
                  if (bit_idx != IW'(DataBits)) begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + IW'(1);
                  end else if (ParityMode != 0) begin
                     tx    <= par;
                     state <= PARITY;
                  end else begin
                     tx       <= 1'b1;
                     stop_idx <= 1'b0;
                     state    <= STOP;
                  end
               end
               PARITY: begin
                  tx       <= 1'b1;
                  stop_idx <= 1'b0;
                  state    <= STOP;
               end
               STOP: begin
                  if (!last_stop)
                     stop_idx <= 1'b1;
                  else
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter: it generalises the single-byte go/bsy transmitter to configurable data width, parity and stop bits. A power-of-two FIFO decouples the producer from the serial line, and frames are sent back-to-back with no idle gap while data is queued. It sits between a CPU/peripheral write port and the board's UART tx pin.

## Interface
- ClockFrequencyHz, 66_000_000, system clock frequency.
- BaudRate, 9600, line rate. BIT_TIME = ClockFrequencyHz / BaudRate (integer division, must be ≥ 1).
- DataBits, 8, data bits per frame, legal range 5..9.
- ParityMode, 0, parity setting: 0 = none, 1 = even, 2 = odd.
- StopBits, 1, number of stop bits, 1 or 2.
- FifoDepth, 16, FIFO entries; a power of two, ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_data  in  DataBits  word to enqueue.
- wr_en  in  1  enqueue request, sampled on each rising edge.
- full  out  1  FIFO holds FifoDepth entries.
- count  out  $clog2(FifoDepth)+1  number of FIFO entries, excluding the word in the shifter.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.
- tx  out  1  serial line; idles high.
- bsy  out  1  high while a frame is in progress or count ≠ 0.

## Operation
- Frame, LSB first:
  - 1 start bit (0).
  - DataBits data bits.
  - Optional parity bit: even parity is XOR of the data bits; odd parity is its inverse.
  - StopBits stop bits (1).
- Every bit lasts exactly BIT_TIME cycles.
- Frame length = BIT_TIME × (1 + DataBits + (ParityMode≠0) + StopBits) cycles.
- FIFO uses read/write pointers with one extra wrap bit.
  - full = pointers equal except the MSB.
  - count = wr_ptr − rd_ptr, modulo 2^($clog2(FifoDepth)+1).
  - Outputs derive only from registers; there is no combinational path from wr_en.
- Write rules:
  - wr_en with full = 0: wr_data is stored.
  - wr_en with full = 1: the write is dropped, FIFO is unchanged, and ovf is set.
  - A pop in the same cycle does not free space for a write seen while full = 1.
- ovf and ovf_clr:
  - ovf_clr clears ovf.
  - If a set (dropped write) and ovf_clr occur in the same cycle, the set wins.
- Shift FSM states: Idle, Start, Data, Parity, Stop. A down-counter runs from BIT_TIME−1 to 0 per bit.
  - Idle, count ≠ 0: pop the head into the shift register, drive tx = 0, load the counter with BIT_TIME−1, go to Start.
  - Start, counter = 0: drive data bit 0, set bit index to 1, go to Data.
  - Data, counter = 0, bit index < DataBits: drive data[bit index], then increment the index.
  - Data, counter = 0, bit index = DataBits: go to Parity (drive the parity bit) if ParityMode ≠ 0, else go to Stop (drive 1).
  - Parity, counter = 0: drive 1, go to Stop.
  - Stop, counter = 0, last stop bit, count ≠ 0: pop the next word, drive 0, go to Start. There is zero idle cycles between frames.
  - Stop, counter = 0, last stop bit, count = 0: go to Idle.
  - Stop, counter = 0, with a second stop bit still to send: reload the counter and stay in Stop.
- Simultaneous write and pop: count stays unchanged, and both operations take effect.
- A write to an empty FIFO while idle is popped on the next edge.
- The shifter holds its own copy of the word. FIFO writes during a frame never alter the frame in flight.
- Reset:
  - Asynchronously forces tx = 1, bsy = 0, full = 0, count = 0, ovf = 0, state Idle, pointers 0.
  - A frame in flight is aborted and queued data is discarded.
  - After deassertion, no frame starts until a new write.

## Timing
- Latency: wr_en sampled at edge k into an empty FIFO with the FSM idle → count = 1 after edge k → tx falls after edge k+1.
- bsy rises after edge k, together with count.
- bsy falls after the final cycle of the last stop bit, provided count = 0.
- Throughput: one frame per frame length while count ≠ 0.
- full asserts after the edge that stores the FifoDepth-th entry.
- full deasserts after the first pop from a full FIFO.

## Test plan
- Send one word with ClockFrequencyHz = 16, BaudRate = 4 (BIT_TIME = 4), DataBits = 8, ParityMode = 0, StopBits = 1.
  - Stimulus: write 8'hA5.
  - Response: tx = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles (40 cycles total).
  - Then tx = 1 and bsy = 0.
- Parity, same stimulus:
  - ParityMode = 1: parity bit = 0, frame is 44 cycles.
  - ParityMode = 2: parity bit = 1.
  - StopBits = 2: tx is high for 8 cycles at the end of the frame.
- DataBits = 5, write 5'h13:
  - Response: tx = 0,1,1,0,0,1,1.
  - Upper wr_data bits do not exist, so there is nothing to ignore.
- Back-to-back and overflow, FifoDepth = 4:
  - Stimulus: six writes on consecutive cycles from idle (0x01..0x06).
  - Response: 0x01..0x05 are accepted, the 6th write is dropped, and ovf = 1.
  - Five frames are sent with no gap between stop and start bits.
  - ovf_clr clears ovf; ovf_clr together with a dropped write leaves ovf = 1.
- Reset mid-frame:
  - Stimulus: assert rst during data bit 3, with 2 words queued.
  - Response: tx = 1, bsy = 0, count = 0 immediately (asynchronously).
  - No output after release until a new write, which then transmits correctly.
- Boundary, BIT_TIME = 1 (ClockFrequencyHz = BaudRate):
  - Response: each bit lasts exactly 1 cycle.
  - A write and a pop in the same cycle keep count constant.
